collision_detector: RTL and testbench
=====================================

Name: collision_detector

Overview:
- Frame-rate hit arbiter between the object-position stages (my bullet, enemy, enemy bullet, my plane) and the scoreboard/7-segment stage.
- Once per frame it tests bounding-box overlap of my bullet vs enemy and enemy bullet vs my plane.
- It counts each distinct collision once and drives the hit/hited counters consumed by the scoreboard.
- It owns the play/game-over state and issues one-cycle despawn pulses back to the bullet stages.

Parameters:
- MY_PLANE_W, 128, my plane box width (px)
- MY_PLANE_H, 128, my plane box height
- ENEMY_W, 128, enemy box width
- ENEMY_H, 128, enemy box height
- MY_BULLET_W, 32, my bullet box width
- MY_BULLET_H, 64, my bullet box height
- ENEMY_BULLET_W, 18, enemy bullet box width
- ENEMY_BULLET_H, 33, enemy bullet box height
- HIT_MAX, 9, saturation value of hit counter (single 7-seg digit)
- LIVES, 3, hited count that ends the game

Ports:
- clk  in  1  65 MHz pixel clock
- rst  in  1  asynchronous, active-low reset
- vs_neg  in  1  one-cycle pulse at vertical-sync falling edge (frame tick)
- restart  in  1  level; sampled only in OVER state
- my_plane_x, my_plane_y  in  11 each  top-left of my plane
- enemy_x, enemy_y  in  11 each  top-left of enemy
- my_bullet_x, my_bullet_y  in  11 each  top-left of my bullet
- enemy_bullet_x, enemy_bullet_y  in  11 each  top-left of enemy bullet
- have_bullet_now  in  1  my bullet is live
- have_enemy_bullet_now  in  1  enemy bullet is live
- hit  out  4  enemies hit by me, saturating
- hited  out  4  times I was hit, saturating at LIVES
- hit_pulse  out  1  one-cycle, my bullet struck enemy (despawn my bullet)
- hited_pulse  out  1  one-cycle, enemy bullet struck me (despawn enemy bullet)
- play  out  1  1 = game running, 0 = game over

Behaviour:
- Reset (rst=0, async):
  - hit=0, hited=0
  - hit_pulse=0, hited_pulse=0
  - play=1, state=PLAY
  - stage-1 flags and previous-frame flags cleared
- Overlap rule, per axis: A.x < B.x+B.w AND B.x < A.x+A.w.
  - Both axes must satisfy the rule.
  - Sums are computed 12 bits wide; no wrap at coordinate 2047.
  - Touching edges (equal values) do not overlap.
- Pipeline, latency 2 cycles from vs_neg:
  - Cycle N: vs_neg=1.
  - Cycle N+1: stage-1 registers hold ov_hit = overlap(my bullet, enemy) AND have_bullet_now, and ov_hited = overlap(enemy bullet, my plane) AND have_enemy_bullet_now.
  - Cycle N+2: counters update and pulses assert for exactly one cycle.
- Inputs are sampled only in cycle N; changes at other times are ignored.
- Once-per-collision rule:
  - A collision counts only if the flag is set this frame and was clear last frame (prev_ov_hit / prev_ov_hited).
  - prev flags update every frame tick, including frames with no event.
  - A persistent overlap therefore counts once.
- Counters:
  - hit increments by 1 until HIT_MAX, then holds.
  - hited increments by 1 until LIVES.
  - hit_pulse still fires when hit is saturated.
- Simultaneous events in one frame: both counters update and both pulses fire in the same cycle.
- FSM:
  - PLAY → OVER in the same cycle hited reaches LIVES; play=0 from that cycle.
  - OVER: no counting, no pulses, stage-1 results discarded; counters frozen.
  - OVER → PLAY on the first vs_neg with restart=1. Counters and prev flags clear; play=1 next cycle; no collision evaluated on that tick.
- Back-to-back vs_neg pulses less than 2 cycles apart are not supported; a frame is at least 1000 cycles.
- Reset mid-pipeline discards in-flight flags; no pulse is emitted after reset release without a new vs_neg.

Decomposition:
- Shared package (game_pkg):
  - sprite size constants
  - COORD_W=11
  - LIVES and HIT_MAX defaults
  - state enum {PLAY, OVER}
- Sub-module box_overlap: combinational, parameterised by the two box sizes. Instantiated twice.

Test Plan:
- Overlap: my bullet (100,100), enemy (120,150), have_bullet_now=1, one vs_neg → hit_pulse high exactly at N+2; hit 0→1; hited stays 0.
- Persistence: same overlap held for 5 frames → hit stays 1; only one hit_pulse. Separate for one frame, then overlap again → hit=2.
- Edge/gating:
  - my bullet x=88, enemy x=120 (88+32=120, touching) → no hit.
  - Overlapping boxes with have_bullet_now=0 → no hit.
- Simultaneous: both collisions in one frame → hit and hited increment together, both pulses in the same cycle.
- Game over: 3 distinct enemy-bullet hits → hited=3, play=0 in the update cycle. Further overlaps are ignored. vs_neg with restart=1 → hit=hited=0, play=1.
- Saturation/reset:
  - 12 distinct bullet hits → hit=9.
  - Assert rst=0 between vs_neg and N+2 → all outputs 0, play=1, no late pulse.

Source files
------------

// File: rtl/game_pkg.sv
// Shared sprite geometry, counter limits and game state for the collision path.
// Box sizes are in pixels. Coordinate sums are one bit wider than a coordinate, so they cannot wrap.
package game_pkg;

   localparam int COORD_W = 11;
   localparam int SUM_W   = COORD_W + 1;
   localparam int CNT_W   = 4;

   localparam int MY_PLANE_W_DEF     = 128;
   localparam int MY_PLANE_H_DEF     = 128;
   localparam int ENEMY_W_DEF        = 128;
   localparam int ENEMY_H_DEF        = 128;
   localparam int MY_BULLET_W_DEF    = 32;
   localparam int MY_BULLET_H_DEF    = 64;
   localparam int ENEMY_BULLET_W_DEF = 18;
   localparam int ENEMY_BULLET_H_DEF = 33;
   localparam int HIT_MAX_DEF        = 9;
   localparam int LIVES_DEF          = 3;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [CNT_W-1:0]   cnt_t;

   typedef enum logic {PLAY, OVER} state_t;

   function automatic cnt_t sat_inc(input cnt_t c, input cnt_t lim);
      return (c < lim) ? c + cnt_t'(1) : c;
   endfunction

endpackage

// File: rtl/collision_detector_if.sv
// Groups the per-frame position and handshake signals between the sprite stages and the collision detector.
// The master side drives positions and frame ticks; the slave side returns the counters, pulses and play state.
interface collision_detector_if;
   import game_pkg::*;

   logic   vs_neg;
   logic   restart;
   coord_t my_plane_x;
   coord_t my_plane_y;
   coord_t enemy_x;
   coord_t enemy_y;
   coord_t my_bullet_x;
   coord_t my_bullet_y;
   coord_t enemy_bullet_x;
   coord_t enemy_bullet_y;
   logic   have_bullet_now;
   logic   have_enemy_bullet_now;
   cnt_t   hit;
   cnt_t   hited;
   logic   hit_pulse;
   logic   hited_pulse;
   logic   play;

   modport master (
      output vs_neg, restart,
      output my_plane_x, my_plane_y, enemy_x, enemy_y,
      output my_bullet_x, my_bullet_y, enemy_bullet_x, enemy_bullet_y,
      output have_bullet_now, have_enemy_bullet_now,
      input  hit, hited, hit_pulse, hited_pulse, play
   );

   modport slave (
      input  vs_neg, restart,
      input  my_plane_x, my_plane_y, enemy_x, enemy_y,
      input  my_bullet_x, my_bullet_y, enemy_bullet_x, enemy_bullet_y,
      input  have_bullet_now, have_enemy_bullet_now,
      output hit, hited, hit_pulse, hited_pulse, play
   );

endinterface

// File: rtl/box_overlap.sv
// Combinational strict bounding-box overlap test between box A and box B. Zero latency and no handshake.
// Touching edges do not count as overlap.
module box_overlap
   import game_pkg::*;
#(
   parameter int A_W = 32,
   parameter int A_H = 64,
   parameter int B_W = 128,
   parameter int B_H = 128
) (
   input  coord_t a_x,
   input  coord_t a_y,
   input  coord_t b_x,
   input  coord_t b_y,
   output logic   overlap
);

   logic [SUM_W-1:0] ax, ay, bx, by;

   assign ax = {1'b0, a_x};
   assign ay = {1'b0, a_y};
   assign bx = {1'b0, b_x};
   assign by = {1'b0, b_y};

   assign overlap = (ax < bx + SUM_W'(B_W)) && (bx < ax + SUM_W'(A_W)) &&
                    (ay < by + SUM_W'(B_H)) && (by < ay + SUM_W'(A_H));

endmodule

// File: rtl/collision_detector.sv
// Samples overlaps on each vs_neg, counts new collisions and runs play/game-over. Latency is 2 cycles from vs_neg to the counter update and pulse.
// No backpressure: the pulses are one-cycle strobes, and vs_neg ticks must be at least 2 cycles apart.
module collision_detector
   import game_pkg::*;
#(
   parameter int MY_PLANE_W     = MY_PLANE_W_DEF,
   parameter int MY_PLANE_H     = MY_PLANE_H_DEF,
   parameter int ENEMY_W        = ENEMY_W_DEF,
   parameter int ENEMY_H        = ENEMY_H_DEF,
   parameter int MY_BULLET_W    = MY_BULLET_W_DEF,
   parameter int MY_BULLET_H    = MY_BULLET_H_DEF,
   parameter int ENEMY_BULLET_W = ENEMY_BULLET_W_DEF,
   parameter int ENEMY_BULLET_H = ENEMY_BULLET_H_DEF,
   parameter int HIT_MAX        = HIT_MAX_DEF,
   parameter int LIVES          = LIVES_DEF
) (
   input logic                clk,
   input logic                rst,
   collision_detector_if.slave bus
);

   logic   ov_hit_c, ov_hited_c;
   logic   s1_vld_q, ov_hit_q, ov_hited_q;
   logic   prev_hit_q, prev_hited_q, prev_hit_d, prev_hited_d;
   logic   hit_pulse_q, hited_pulse_q, hit_pulse_d, hited_pulse_d;
   cnt_t   hit_q, hited_q, hit_d, hited_d;
   state_t state_q, state_d;

   box_overlap #(
      .A_W(MY_BULLET_W), .A_H(MY_BULLET_H), .B_W(ENEMY_W), .B_H(ENEMY_H)
   ) u_ov_hit (
      .a_x(bus.my_bullet_x), .a_y(bus.my_bullet_y),
      .b_x(bus.enemy_x),     .b_y(bus.enemy_y),
      .overlap(ov_hit_c)
   );

   box_overlap #(
      .A_W(ENEMY_BULLET_W), .A_H(ENEMY_BULLET_H), .B_W(MY_PLANE_W), .B_H(MY_PLANE_H)
   ) u_ov_hited (
      .a_x(bus.enemy_bullet_x), .a_y(bus.enemy_bullet_y),
      .b_x(bus.my_plane_x),     .b_y(bus.my_plane_y),
      .overlap(ov_hited_c)
   );

   // Stage 1 captures the gated overlaps only on the frame tick; the valid is suppressed in OVER.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_vld_q   <= 1'b0;
         ov_hit_q   <= 1'b0;
         ov_hited_q <= 1'b0;
      end else begin
         s1_vld_q <= bus.vs_neg && (state_q == PLAY);
         if (bus.vs_neg) begin
            ov_hit_q   <= ov_hit_c && bus.have_bullet_now;
            ov_hited_q <= ov_hited_c && bus.have_enemy_bullet_now;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= PLAY;
         hit_q         <= '0;
         hited_q       <= '0;
         prev_hit_q    <= 1'b0;
         prev_hited_q  <= 1'b0;
         hit_pulse_q   <= 1'b0;
         hited_pulse_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         hit_q         <= hit_d;
         hited_q       <= hited_d;
         prev_hit_q    <= prev_hit_d;
         prev_hited_q  <= prev_hited_d;
         hit_pulse_q   <= hit_pulse_d;
         hited_pulse_q <= hited_pulse_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      hit_d         = hit_q;
      hited_d       = hited_q;
      prev_hit_d    = prev_hit_q;
      prev_hited_d  = prev_hited_q;
      hit_pulse_d   = 1'b0;
      hited_pulse_d = 1'b0;
      case (state_q)
         PLAY: begin
            if (s1_vld_q) begin
               prev_hit_d   = ov_hit_q;
               prev_hited_d = ov_hited_q;
               // Only a rising flag counts, so a lingering overlap scores once.
               if (ov_hit_q && !prev_hit_q) begin
                  hit_pulse_d = 1'b1;
                  hit_d       = sat_inc(hit_q, cnt_t'(HIT_MAX));
               end
               if (ov_hited_q && !prev_hited_q) begin
                  hited_pulse_d = 1'b1;
                  hited_d       = sat_inc(hited_q, cnt_t'(LIVES));
               end
               if (hited_d == cnt_t'(LIVES)) begin
                  state_d = OVER;
               end
            end
         end
         OVER: begin
            if (bus.vs_neg && bus.restart) begin
               state_d      = PLAY;
               hit_d        = '0;
               hited_d      = '0;
               prev_hit_d   = 1'b0;
               prev_hited_d = 1'b0;
            end
         end
         default: state_d = PLAY;
      endcase
   end

   assign bus.hit         = hit_q;
   assign bus.hited       = hited_q;
   assign bus.hit_pulse   = hit_pulse_q;
   assign bus.hited_pulse = hited_pulse_q;
   assign bus.play        = (state_q == PLAY);

endmodule

// File: tb/tb_collision_detector.sv
// Directed bench for collision_detector: frame ticks with hand-placed sprites, checking pulse timing and counters.
module tb_collision_detector;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   collision_detector_if cd_if ();

   collision_detector dut (
      .clk(clk),
      .rst(rst),
      .bus(cd_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic bullet_at(input int x, input int y, input logic live);
      cd_if.my_bullet_x     = 11'(x);
      cd_if.my_bullet_y     = 11'(y);
      cd_if.have_bullet_now = live;
   endtask

   task automatic ebullet_at(input int x, input int y, input logic live);
      cd_if.enemy_bullet_x        = 11'(x);
      cd_if.enemy_bullet_y        = 11'(y);
      cd_if.have_enemy_bullet_now = live;
   endtask

   // One frame tick; the pulses must show only in cycle N+2.
   task automatic frame_chk(input string tag, input int exp_hp, input int exp_hdp);
      int stray;
      int hp, hdp;
      stray = 0;
      @(posedge clk); #1 cd_if.vs_neg = 1'b1;
      @(posedge clk); #1 cd_if.vs_neg = 1'b0;
      stray += int'(cd_if.hit_pulse) + int'(cd_if.hited_pulse);
      @(posedge clk); #1;
      hp  = int'(cd_if.hit_pulse);
      hdp = int'(cd_if.hited_pulse);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         stray += int'(cd_if.hit_pulse) + int'(cd_if.hited_pulse);
      end
      chk({tag, "_hit_pulse"}, hp, exp_hp);
      chk({tag, "_hited_pulse"}, hdp, exp_hdp);
      chk({tag, "_stray_pulses"}, stray, 0);
   endtask

   initial begin
      int n_hp;
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b0;
      cd_if.vs_neg     = 1'b0;
      cd_if.restart    = 1'b0;
      cd_if.my_plane_x = 11'd500;
      cd_if.my_plane_y = 11'd600;
      cd_if.enemy_x    = 11'd120;
      cd_if.enemy_y    = 11'd150;
      bullet_at(100, 100, 1'b1);
      ebullet_at(1000, 700, 1'b1);

      #3;
      chk("rst_hit", cd_if.hit, 0);
      chk("rst_hited", cd_if.hited, 0);
      chk("rst_hit_pulse", cd_if.hit_pulse, 0);
      chk("rst_hited_pulse", cd_if.hited_pulse, 0);
      chk("rst_play", cd_if.play, 1);
      #20 rst = 1'b1;
      repeat (2) @(posedge clk);

      // Bullet (100,100) 32x64 overlaps enemy (120,150) 128x128.
      frame_chk("first", 1, 0);
      chk("first_hit", cd_if.hit, 1);
      chk("first_hited", cd_if.hited, 0);

      for (int f = 0; f < 4; f++) frame_chk("persist", 0, 0);
      chk("persist_hit", cd_if.hit, 1);

      bullet_at(500, 100, 1'b1);
      frame_chk("apart", 0, 0);
      bullet_at(100, 100, 1'b1);
      frame_chk("again", 1, 0);
      chk("again_hit", cd_if.hit, 2);

      // 88+32 == 120: edges touch, no overlap.
      bullet_at(88, 100, 1'b1);
      frame_chk("touch_x", 0, 0);
      bullet_at(100, 100, 1'b0);
      frame_chk("not_live", 0, 0);
      chk("gate_hit", cd_if.hit, 2);

      // Enemy bullet (510,610) 18x33 overlaps plane (500,600).
      bullet_at(100, 100, 1'b1);
      ebullet_at(510, 610, 1'b1);
      frame_chk("both", 1, 1);
      chk("both_hit", cd_if.hit, 3);
      chk("both_hited", cd_if.hited, 1);
      chk("both_play", cd_if.play, 1);

      // 567+33 == 600: touching in y.
      bullet_at(88, 100, 1'b1);
      ebullet_at(510, 567, 1'b1);
      frame_chk("touch_y", 0, 0);
      ebullet_at(510, 610, 1'b1);
      frame_chk("hited2", 0, 1);
      chk("hited2_val", cd_if.hited, 2);
      ebullet_at(510, 567, 1'b1);
      frame_chk("apart2", 0, 0);
      ebullet_at(510, 610, 1'b1);
      frame_chk("hited3", 0, 1);
      chk("over_hited", cd_if.hited, 3);
      chk("over_play", cd_if.play, 0);

      ebullet_at(510, 567, 1'b1);
      frame_chk("over_apart", 0, 0);
      bullet_at(100, 100, 1'b1);
      ebullet_at(510, 610, 1'b1);
      frame_chk("over_ignored", 0, 0);
      chk("over_hit_frozen", cd_if.hit, 3);
      chk("over_hited_frozen", cd_if.hited, 3);
      chk("over_play_held", cd_if.play, 0);

      cd_if.restart = 1'b1;
      frame_chk("restart", 0, 0);
      cd_if.restart = 1'b0;
      chk("restart_hit", cd_if.hit, 0);
      chk("restart_hited", cd_if.hited, 0);
      chk("restart_play", cd_if.play, 1);
      // Overlap held across the restart still counts: previous-frame flags were cleared.
      frame_chk("post_restart", 1, 1);
      chk("post_restart_hit", cd_if.hit, 1);
      chk("post_restart_hited", cd_if.hited, 1);

      ebullet_at(510, 567, 1'b1);
      n_hp = 0;
      for (int k = 0; k < 12; k++) begin
         bullet_at(88, 100, 1'b1);
         frame_chk("sat_apart", 0, 0);
         bullet_at(100, 100, 1'b1);
         frame_chk("sat_hit", 1, 0);
         n_hp++;
      end
      chk("sat_hit_val", cd_if.hit, 9);
      chk("sat_pulse_frames", n_hp, 12);
      chk("sat_play", cd_if.play, 1);

      bullet_at(88, 100, 1'b1);
      frame_chk("pre_rst", 0, 0);
      bullet_at(100, 100, 1'b1);
      @(posedge clk); #1 cd_if.vs_neg = 1'b1;
      @(posedge clk); #1 cd_if.vs_neg = 1'b0;
      rst = 1'b0;
      #1;
      chk("midrst_hit", cd_if.hit, 0);
      chk("midrst_hited", cd_if.hited, 0);
      chk("midrst_hit_pulse", cd_if.hit_pulse, 0);
      chk("midrst_hited_pulse", cd_if.hited_pulse, 0);
      chk("midrst_play", cd_if.play, 1);
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      n_hp = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         n_hp += int'(cd_if.hit_pulse) + int'(cd_if.hited_pulse);
      end
      chk("midrst_late_pulse", n_hp, 0);
      chk("midrst_hit_after", cd_if.hit, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
